zap_predecode_copro_dispatch: RTL

Multi-channel coprocessor dispatch stage for the ZAP predecode path. It sits between the fetch-side instruction stream and decode. It classifies ARM coprocessor instructions (CDP/MRC/MCR/LDC/STC and their `*2` forms), routes each one to one of `NUM_CP` coprocessor channels by coprocessor number, and stalls the front end until the selected channel signals completion. Unmapped or privilege-violating coprocessor accesses are flagged undefined instead of being silently passed through. An optional timeout releases a hung channel.

---
 rtl/zap_predecode_copro_dispatch.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/zap_predecode_copro_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : zap_predecode_copro_dispatch
// Description : Coprocessor dispatch stage for the ZAP predecode path.
//               Detects CDP/MRC/MCR/LDC/STC (and *2 forms) and routes each
//               to one of NUM_CP channels by coprocessor number. The front
//               end stalls until the selected channel reports done.
//               Unmapped or USR-mode-forbidden accesses raise o_und.
//               Optional macro ZAP_COPRO_TIMEOUT_EN releases a hung channel
//               after TIMEOUT_CYCLES BUSY cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module zap_predecode_copro_dispatch #(
    parameter int          NUM_CP         = 1,
    parameter logic [3:0]  CP_BASE        = 4'd15,
    parameter logic [15:0] USR_MASK       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [34:0]       i_instruction,
    input  logic              i_valid,
    input  logic              i_cpsr_ff_t,
    input  logic [4:0]        i_cpsr_ff_mode,
    input  logic              i_irq,
    input  logic              i_fiq,
    input  logic              i_clear_from_writeback,
    input  logic              i_data_stall,
    input  logic              i_clear_from_alu,
    input  logic              i_stall_from_shifter,
    input  logic              i_stall_from_issue,
    input  logic              i_clear_from_decode,
    input  logic              i_pipeline_dav,
    input  logic [NUM_CP-1:0] i_copro_done,
    output logic              o_irq,
    output logic              o_fiq,
    output logic [34:0]       o_instruction,
    output logic              o_valid,
    output logic              o_und,
    output logic              o_stall_from_decode,
    output logic [NUM_CP-1:0] o_copro_dav,
    output logic [31:0]       o_copro_word
);

    // Channel window [CP_BASE, CP_END) in 5 bits so CP_END may equal 16.
    localparam logic [4:0] USR_MODE = 5'b10000;
    localparam logic [4:0] CP_END   = {1'b0, CP_BASE} + 5'(NUM_CP);

    // Reject configurations that would map channels past p15.
    if ((int'(CP_BASE) + NUM_CP > 16) || (NUM_CP < 1)) begin : g_bad_channel_map
        $error("zap_predecode_copro_dispatch: CP_BASE+NUM_CP must be <= 16 and NUM_CP >= 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("zap_predecode_copro_dispatch: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NUM_CP-1:0] dav_nxt;
    logic [31:0]       word_nxt;

    logic              cp_op;
    logic [3:0]        cpn;
    logic [3:0]        ch;
    logic              in_range;
    logic              priv_ok;
    logic              eligible;
    logic [NUM_CP-1:0] ch_onehot;
    logic              done_hit;
    logic              timeout_hit;

    // Classification ignores the condition field; the Thumb state and the
    // extended opcode bits [34:32] exclude non-native encodings.
    assign cp_op    = i_valid && !i_cpsr_ff_t && (i_instruction[34:32] == 3'b000) &&
                      ((i_instruction[27:24] == 4'b1110) || (i_instruction[27:25] == 3'b110));
    assign cpn      = i_instruction[11:8];
    assign ch       = cpn - CP_BASE;
    assign in_range = (cpn >= CP_BASE) && ({1'b0, cpn} < CP_END);
    assign priv_ok  = (i_cpsr_ff_mode != USR_MODE) || USR_MASK[cpn];
    assign eligible = cp_op && in_range && priv_ok;

    // Only the channel currently being requested may complete the transaction.
    assign done_hit = (state == ST_BUSY) && (|(i_copro_done & o_copro_dav));

    assign o_instruction = i_instruction;
    assign o_valid       = i_valid;

`ifdef ZAP_COPRO_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    assign timeout_hit = (state == ST_BUSY) && (cnt == CNT_LAST) && !done_hit;
`else
    assign timeout_hit = 1'b0;
`endif

    // Decode the channel index into the one-hot request vector.
    always_comb begin
        ch_onehot = '0;
        for (int k = 0; k < NUM_CP; k++) begin
            ch_onehot[k] = (ch == 4'(k));
        end
    end

    // Front-end facing outputs: stall and interrupt masking while a
    // coprocessor op is pending or in flight, UND for illegal accesses.
    always_comb begin
        o_stall_from_decode = 1'b0;
        o_und               = 1'b0;
        o_irq               = i_irq;
        o_fiq               = i_fiq;
        case (state)
            ST_IDLE: begin
                if (eligible) begin
                    o_stall_from_decode = 1'b1;
                    o_irq               = 1'b0;
                    o_fiq               = 1'b0;
                end else if (cp_op) begin
                    o_und = 1'b1;
                end
            end
            ST_BUSY: begin
                o_irq               = 1'b0;
                o_fiq               = 1'b0;
                o_stall_from_decode = !(done_hit || timeout_hit);
                o_und               = timeout_hit;
            end
            default: begin
                o_stall_from_decode = 1'b0;
            end
        endcase
    end

    // Next-state selection: clears and holds in their fixed priority order,
    // otherwise the IDLE/BUSY transition rules. A clear keeps the last word.
    always_comb begin
        state_nxt = state;
        dav_nxt   = o_copro_dav;
        word_nxt  = o_copro_word;
`ifdef ZAP_COPRO_TIMEOUT_EN
        cnt_nxt   = cnt;
`endif
        if (i_clear_from_writeback ||
            (!i_data_stall && i_clear_from_alu) ||
            (!i_data_stall && !i_stall_from_shifter && !i_stall_from_issue &&
             i_clear_from_decode)) begin
            state_nxt = ST_IDLE;
            dav_nxt   = '0;
`ifdef ZAP_COPRO_TIMEOUT_EN
            cnt_nxt   = '0;
`endif
        end else if (i_data_stall || i_stall_from_shifter || i_stall_from_issue) begin
            state_nxt = state;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (eligible && !i_pipeline_dav) begin
                        state_nxt = ST_BUSY;
                        dav_nxt   = ch_onehot;
                        word_nxt  = i_instruction[31:0];
                    end
                end
                ST_BUSY: begin
                    if (done_hit || timeout_hit) begin
                        state_nxt = ST_IDLE;
                        dav_nxt   = '0;
`ifdef ZAP_COPRO_TIMEOUT_EN
                        cnt_nxt   = '0;
`endif
                    end else begin
`ifdef ZAP_COPRO_TIMEOUT_EN
                        cnt_nxt   = cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    dav_nxt   = '0;
                end
            endcase
        end
    end

    // State and request registers; reset drops any in-flight request at once.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            o_copro_dav  <= '0;
            o_copro_word <= '0;
        end else begin
            state        <= state_nxt;
            o_copro_dav  <= dav_nxt;
            o_copro_word <= word_nxt;
        end
    end

`ifdef ZAP_COPRO_TIMEOUT_EN
    // BUSY-cycle counter used to release a channel that never answers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`endif

endmodule
`default_nettype wire
